// File: rtl/top_latch.sv
// Dictionary-based instruction decompressor feeding CPU fetch.
// Tracks the last fetched PC and decodes the current and next instruction.
module top_latch #(
  parameter int DATA_W = 32,
  parameter int TOKEN_W = 4,
  parameter logic [DATA_W-1:0] PC_INC = 32'b100,
  parameter logic [TOKEN_W-1:0] ESC_TOKEN = 4'b1111,
  parameter int TT_DEPTH = 32,
  parameter int MEM_DEPTH = 77,
  parameter logic [TT_DEPTH*DATA_W-1:0] TOKEN_IMG = '0,
  parameter logic [MEM_DEPTH*DATA_W-1:0] PROG_IMG = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] PCcpu,
  output logic [DATA_W-1:0] DecompressInstr
);

  localparam int SW = MEM_DEPTH * DATA_W;
  localparam int PW = $clog2(SW) + 1;
  localparam int OW = $clog2(DATA_W);
  localparam int WW = 3 * DATA_W;

  logic [DATA_W-1:0] last_pc;
  logic [PW-1:0]     bit_ptr;
  logic [PW-1:0]     cur_len;
  logic [DATA_W-1:0] cur_instr;
  logic [DATA_W-1:0] nxt_instr;
  logic [DATA_W-1:0] pc_next;

  // Image word 0 sits in the top bits, so the image reads as the stream
  function automatic logic [DATA_W-1:0] rd(input int idx);
    if (idx < MEM_DEPTH)
      return PROG_IMG[SW-1-idx*DATA_W -: DATA_W];
    return '0;
  endfunction

  function automatic logic [DATA_W-1:0] tt_rd(input int idx);
    if (idx < TT_DEPTH)
      return TOKEN_IMG[TT_DEPTH*DATA_W-1-idx*DATA_W -: DATA_W];
    return '0;
  endfunction

  // Three words cover a token plus literal at any bit offset
  function automatic logic [WW-1:0] window(
    input logic [PW-1:0] ptr
  );
    int w;
    logic [WW-1:0] win;
    w   = int'(ptr >> OW);
    win = {rd(w), rd(w + 1), rd(w + 2)};
    return win << ptr[OW-1:0];
  endfunction

  function automatic logic [PW-1:0] dec_len(
    input logic [PW-1:0] ptr
  );
    logic [WW-1:0] sh;
    sh = window(ptr);
    if (sh[WW-1 -: TOKEN_W] == ESC_TOKEN)
      return PW'(TOKEN_W + DATA_W);
    return PW'(TOKEN_W);
  endfunction

  function automatic logic [DATA_W-1:0] dec_instr(
    input logic [PW-1:0] ptr
  );
    logic [WW-1:0] sh;
    logic [TOKEN_W-1:0] tok;
    sh  = window(ptr);
    tok = sh[WW-1 -: TOKEN_W];
    if (tok == ESC_TOKEN)
      return sh[WW-1-TOKEN_W -: DATA_W];
    return tt_rd(int'(tok));
  endfunction

  assign pc_next   = last_pc + PC_INC;
  assign cur_len   = dec_len(bit_ptr);
  assign cur_instr = dec_instr(bit_ptr);
  assign nxt_instr = dec_instr(bit_ptr + cur_len);

  always_comb begin
    DecompressInstr = '0;
    unique case (1'b1)
      (PCcpu == last_pc): DecompressInstr = cur_instr;
      (PCcpu == pc_next): DecompressInstr = nxt_instr;
      default:            DecompressInstr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_pc <= '0;
      bit_ptr <= '0;
    end else if (PCcpu == pc_next) begin
      last_pc <= PCcpu;
      bit_ptr <= bit_ptr + cur_len;
    end
  end

endmodule

// File: tb/tb_top_latch.sv
// Directed bench for top_latch with a small hand-built stream image.
// Expected instructions are written out by hand from the nibble layout.
module tb_top_latch;

  function automatic logic [31:0] tt(input int i);
    if (i == 14) return 32'h1EFF2FE1;
    return 32'h7700_0000 | (i << 8) | i;
  endfunction

  function automatic logic [1023:0] mk_tt();
    logic [1023:0] v;
    v = '0;
    for (int i = 0; i < 32; i++)
      v[1023-i*32 -: 32] = tt(i);
    return v;
  endfunction

  localparam logic [1023:0] TT_IMG = mk_tt();
  localparam logic [77*32-1:0] PG_IMG = {
    32'h30E57F12, 32'h34567821, 32'h4689ABCF,
    32'hDEADBEEF, 32'hDF0BADF0, 32'h0D0E0000,
    {(71*32){1'b0}}
  };

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  int          n_cmp;
  int          n_bad;

  top_latch #(
    .TOKEN_IMG(TT_IMG),
    .PROG_IMG (PG_IMG)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .PCcpu          (pc),
    .DecompressInstr(instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] golden(input int k);
    unique case (k)
      0:  return tt(3);
      1:  return tt(0);
      2:  return tt(14);
      3:  return tt(5);
      4:  return tt(7);
      5:  return 32'h12345678;
      6:  return tt(2);
      7:  return tt(1);
      8:  return tt(4);
      9:  return tt(6);
      10: return tt(8);
      11: return tt(9);
      12: return tt(10);
      13: return tt(11);
      14: return tt(12);
      15: return 32'hDEADBEEF;
      16: return tt(13);
      17: return 32'h0BADF00D;
      18: return tt(0);
      19: return tt(14);
      default: return tt(0);
    endcase
  endfunction

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic fetch(input int k);
    @(negedge clk);
    pc = 32'(k * 4);
    #1 check($sformatf("seq%0d", k), instr, golden(k));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    pc    = '0;
    repeat (2) @(posedge clk);
    #1 check("rst_out", instr, golden(0));
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check($sformatf("hold0_%0d", i), instr, golden(0));
    end

    for (int k = 1; k <= 32; k++) begin
      fetch(k);
      if (k == 8) begin
        @(posedge clk);
        #1 check("stall8", instr, golden(8));
      end
      if (k == 4) begin
        @(negedge clk);
        pc = 32'h40;
        #1 check("nonseq", instr, 32'h0);
        @(negedge clk);
        pc = 32'h10;
        #1 check("resume_cur", instr, golden(4));
      end
    end

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 check("rst_mid", instr, 32'h0);
    @(negedge clk);
    pc    = '0;
    reset = 1'b1;
    #1 check("rst_first", instr, golden(0));
    for (int k = 1; k <= 20; k++)
      fetch(k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
